// File: rtl/nyq_sample_fifo.sv
// Sample FIFO behind the Nyquist decimator: arithmetic-shift gain on capture, show-ahead valid/ready output.
// Optional build macro NYQ_FIFO_ROUND_EN adds round-half-up with saturation ahead of the shift.
module nyq_sample_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 24,
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
  input  logic [DATA_WIDTH-1:0] In_DI,
  input  logic                  InValid_SI,
  output logic [DATA_WIDTH-1:0] Out_DO,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI,
  output logic [DEPTH_LOG2:0]   Level_DO,
  output logic                  Full_SO,
  output logic                  Overflow_SO
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [4:0] SHIFT_MAX = 5'(DATA_WIDTH - 1);

  logic [4:0]            shift_q;
  logic                  flush_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
  logic [DATA_WIDTH-1:0] gained;
  logic                  empty, full, pop, push;
  logic                  unused_par;

  // Only the low shift field and the flush bit are architected; the rest is don't-care.
  assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:5];

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      shift_q <= '0;
      flush_q <= 1'b0;
    end else if (WrEn_SI) begin
      if (Addr_DI == ADDR_WIDTH'(0))
        shift_q <= (PAR_In_DI[4:0] > SHIFT_MAX) ? SHIFT_MAX : PAR_In_DI[4:0];
      else if (Addr_DI == ADDR_WIDTH'(1))
        flush_q <= PAR_In_DI[0];
    end
  end

`ifdef NYQ_FIFO_ROUND_EN
  logic signed [DATA_WIDTH:0] rnd_half, rnd_ext, rnd_shf;

  always_comb begin
    rnd_half = '0;
    if (shift_q != 5'd0)
      rnd_half[shift_q - 5'd1] = 1'b1;
    rnd_ext = $signed({In_DI[DATA_WIDTH-1], In_DI}) + rnd_half;
    rnd_shf = rnd_ext >>> shift_q;
    // Top two bits disagree only when the rounded result left the signed sample range.
    if (rnd_shf[DATA_WIDTH] != rnd_shf[DATA_WIDTH-1])
      gained = {rnd_shf[DATA_WIDTH], {(DATA_WIDTH-1){~rnd_shf[DATA_WIDTH]}}};
    else
      gained = rnd_shf[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    gained = $signed(In_DI) >>> shift_q;
  end
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign pop   = !flush_q && !empty && OutReady_SI;
  assign push  = !flush_q && InValid_SI && (!full || pop);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (flush_q) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (InValid_SI && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between rd_ptr and wr_ptr.
  always_ff @(posedge Clk_CI) begin
    if (push)
      fifo_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= gained;
  end

  assign Out_DO      = empty ? '0 : fifo_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign OutValid_SO = !empty;
  assign Level_DO    = wr_ptr_q - rd_ptr_q;
  assign Full_SO     = full;
  assign Overflow_SO = overflow_q;

endmodule

// File: doc/nyq_sample_fifo.md
Name: nyq_sample_fifo

Overview:
Downstream stage of the Nyquist decimation filter. It captures each decimated 24-bit sample on the filter's one-cycle valid strobe and applies a programmable arithmetic right-shift gain. Samples are buffered in a small FIFO and presented to the next consumer over a valid/ready handshake. It decouples the filter's fixed 1-in-8 output cadence from a consumer that may stall.

Parameters:
ADDR_WIDTH, 5, parameter memory holds 2^ADDR_WIDTH entries (common to all blocks)
MEM_WIDTH, 24, width of each parameter memory word
DATA_WIDTH, 24, sample width, in and out, signed
DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (default 8)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous reset, active-low
WrEn_SI  in  1  parameter memory write enable, active high
Addr_DI  in  ADDR_WIDTH  parameter memory address
PAR_In_DI  in  MEM_WIDTH  parameter write data
In_DI  in  DATA_WIDTH  signed sample from the Nyquist filter
InValid_SI  in  1  one-cycle strobe: In_DI valid this cycle
Out_DO  out  DATA_WIDTH  signed head-of-FIFO sample
OutValid_SO  out  1  FIFO non-empty
OutReady_SI  in  1  consumer accepts Out_DO this cycle
Level_DO  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
Full_SO  out  1  occupancy == 2^DEPTH_LOG2
Overflow_SO  out  1  sticky: a sample was dropped

Behaviour:
- Reset (async, Rst_RBI=0): all parameter words=0; rd/wr pointers=0; Level_DO=0; OutValid_SO=0; Full_SO=0; Overflow_SO=0; Out_DO=0.
- Parameter memory: same write-only register array as the other blocks; write on posedge when WrEn_SI=1.
  - mem[0][4:0] = shift S. Values >23 clamp to 23.
  - mem[1][0] = Flush. While 1: pointers and Level held at 0, Overflow_SO cleared, inputs ignored.
  - Other addresses are unused.
- Gain: stored = In_DI >>> S (arithmetic, truncate toward -inf). Computed combinationally at capture. S is sampled on the same edge as the push, so a new S applies from the next push.
- Push: on posedge with InValid_SI=1 and Flush=0. Accepted if !Full_SO, or if Full_SO and a pop occurs in the same cycle.
- Pop: on posedge with OutValid_SO=1 and OutReady_SI=1. rd_ptr increments.
- Show-ahead read: Out_DO = entry[rd_ptr] when non-empty, 0 when empty.
- Latency: a sample pushed at edge k is visible (OutValid_SO=1, Out_DO) right after edge k when the FIFO was empty.
- Simultaneous push and pop: Level unchanged; both pointers advance.
- Push while empty with OutReady_SI=1: push only; no pop that cycle.
- Overflow: push attempted while full with no pop → sample dropped, Overflow_SO set after the edge. It stays set until Flush or reset.
- Pointers are DEPTH_LOG2+1 bits and wrap naturally.
  - Full = MSBs differ and LSBs equal.
  - Empty = pointers equal.
- Out_DO, OutValid_SO, Full_SO and Level_DO derive from registered state only; no combinational path from inputs.
- Reset asserted mid-operation: immediate clear to reset values. The FIFO contents are not required to clear; they are unreachable.

Optional Feature:
NYQ_FIFO_ROUND_EN
- Defined: round-half-up before shift. Stored = sat((In_DI + 2^(S-1)) >>> S), computed at DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range.
  - Example: S=1, In=0x7FFFFF → 0x400000, no overflow.
  - S=0 means no rounding add.
- Undefined: plain truncating shift as above.

Test Plan:
1. Reset, S=0; push 0x123456, consumer OutReady_SI=1 → OutValid_SO=1 one edge after push with Out_DO=0x123456; popped next edge; Level_DO returns to 0.
2. Write mem[0]=2; push 0xFFFFF0 (-16) → Out_DO=0xFFFFFC (-4). Push 0x000007 → 0x000001 (0x000002 with NYQ_FIFO_ROUND_EN).
3. OutReady_SI=0; push 8 samples 1..8 → Full_SO=1, Level_DO=8. 9th push → dropped, Overflow_SO=1. Drain → outputs 1..8 in order; Overflow_SO stays 1.
4. Full FIFO; same-cycle push 0x0000AA and pop → Level_DO stays 8, Overflow_SO unchanged; 0x0000AA emerges as the 8th output after the drain.
5. Write mem[1]=1 with Level_DO=5 → Level_DO=0, OutValid_SO=0, Overflow_SO=0; pushes ignored until mem[1]=0.
6. Assert Rst_RBI low between edges with Level_DO=3 → all outputs 0 immediately; S reads back as 0 (next push unshifted).
